// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing defaults, coordinate type and timing helpers.
// No ports; imported by vga_sync_gen_if, vga_clk_div and vga_sync_gen.
package vga_pkg;

    localparam int DEF_CLK_DIV   = 4;
    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;
    localparam int MAX_TOTAL     = 1024;

    typedef logic [9:0] vga_coord_t;

    function automatic int h_total(int vis, int front, int sync, int back);
        return vis + front + sync + back;
    endfunction

    function automatic int v_total(int vis, int front, int sync, int back);
        return vis + front + sync + back;
    endfunction

    // True when p lies in the half-open window [lo, lo+len).
    function automatic logic in_win(int p, int lo, int len);
        return (p >= lo) && (p < lo + len);
    endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: raster timing bundle from the sync generator to the pixel stages.
// Signals: pos_h, pos_v (coordinates), blank, hsync, vsync, pix_tick, frame_start.
// Modports: master (generator drives), slave (colour stages consume).
interface vga_sync_gen_if;
    import vga_pkg::*;

    vga_coord_t pos_h;
    vga_coord_t pos_v;
    logic       blank;
    logic       hsync;
    logic       vsync;
    logic       pix_tick;
    logic       frame_start;

    modport master (output pos_h, pos_v, blank, hsync, vsync, pix_tick, frame_start);
    modport slave  (input  pos_h, pos_v, blank, hsync, vsync, pix_tick, frame_start);

endinterface

// File: rtl/vga_clk_div.sv
// vga_clk_div: pixel-rate strobe by integer division of the system clock.
// Ports: clk (system clock), rst (async active-high reset), tick (one-clk strobe every CLK_DIV clks).
module vga_clk_div #(
    parameter int CLK_DIV = vga_pkg::DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    if (CLK_DIV < 1) begin : g_div_chk
        $error("vga_clk_div: CLK_DIV must be >= 1");
    end

    logic [W-1:0] cnt_q, cnt_d;
    logic         wrap;

    assign wrap  = cnt_q == LAST;
    assign cnt_d = wrap ? '0 : cnt_q + 1'b1;
    // Gated by rst so the strobe reads 0 while in reset, even when CLK_DIV=1.
    assign tick  = wrap & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: raster timing generator (pixel position, blank, hsync, vsync, frame_start).
// Ports: clk (system clock), rst (async active-high reset),
//        vga_o (vga_sync_gen_if.master: pos_h, pos_v, blank, hsync, vsync, pix_tick, frame_start).
// Build option: VGA_SYNC_ALIGN_EN adds one clk register on hsync/vsync to line up with
//               the registered colour output of the downstream pixel stages.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    vga_sync_gen_if.master        vga_o
);
    localparam int H_TOTAL = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
    localparam vga_coord_t H_LAST = vga_coord_t'(H_TOTAL - 1);
    localparam vga_coord_t V_LAST = vga_coord_t'(V_TOTAL - 1);

    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_total_chk
        $error("vga_sync_gen: H_TOTAL and V_TOTAL must be <= 1024");
    end

    logic       tick;
    vga_coord_t pos_h_q, pos_h_d, pos_v_q, pos_v_d;
    logic       blank_q, blank_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
    logic       h_wrap, v_wrap;

    vga_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Decode from the next-state counters so the registered flags change on the
    // same edge as the coordinates; pos_v only moves at a line wrap, so vsync
    // edges land on pos_h = 0.
    always_comb begin
        h_wrap  = pos_h_q == H_LAST;
        v_wrap  = pos_v_q == V_LAST;
        pos_h_d = tick ? (h_wrap ? '0 : pos_h_q + 1'b1) : pos_h_q;
        pos_v_d = (tick && h_wrap) ? (v_wrap ? '0 : pos_v_q + 1'b1) : pos_v_q;
        fs_d    = tick & h_wrap & v_wrap;
        blank_d = (int'(pos_h_d) >= H_VISIBLE) || (int'(pos_v_d) >= V_VISIBLE);
        hs_d    = in_win(int'(pos_h_d), H_VISIBLE + H_FRONT, H_SYNC) ? SYNC_POL : ~SYNC_POL;
        vs_d    = in_win(int'(pos_v_d), V_VISIBLE + V_FRONT, V_SYNC) ? SYNC_POL : ~SYNC_POL;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_h_q <= '0;
            pos_v_q <= '0;
            blank_q <= 1'b0;
            fs_q    <= 1'b0;
            hs_q    <= ~SYNC_POL;
            vs_q    <= ~SYNC_POL;
        end else begin
            pos_h_q <= pos_h_d;
            pos_v_q <= pos_v_d;
            blank_q <= blank_d;
            fs_q    <= fs_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
        end
    end

`ifdef VGA_SYNC_ALIGN_EN
    logic hs_al_q, vs_al_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_al_q <= ~SYNC_POL;
            vs_al_q <= ~SYNC_POL;
        end else begin
            hs_al_q <= hs_q;
            vs_al_q <= vs_q;
        end
    end

    assign vga_o.hsync = hs_al_q;
    assign vga_o.vsync = vs_al_q;
`else
    assign vga_o.hsync = hs_q;
    assign vga_o.vsync = vs_q;
`endif

    assign vga_o.pos_h       = pos_h_q;
    assign vga_o.pos_v       = pos_v_q;
    assign vga_o.blank       = blank_q;
    assign vga_o.pix_tick    = tick;
    assign vga_o.frame_start = fs_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: randomized bench for vga_sync_gen against an absolute-tick-count model.
// DUT a: default 640x480 timing, CLK_DIV=4. DUT b: small raster, CLK_DIV=1, active-high sync.
module tb_vga_sync_gen;

    localparam int BH_V = 20, BH_F = 3, BH_S = 4, BH_B = 5;
    localparam int BV_V = 10, BV_F = 2, BV_S = 2, BV_B = 3;
    localparam int B_FRAME = (BH_V + BH_F + BH_S + BH_B) * (BV_V + BV_F + BV_S + BV_B);

    typedef struct {
        int h;
        int v;
        bit blank;
        bit hs;
        bit vs;
        bit tick;
        bit fs;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    bit   chk_en = 1'b0;
    int   c_a = 0;
    int   c_b = 0;
    int   last_fs = -1;
    int   n_chk = 0;
    int   n_err = 0;

    vga_sync_gen_if ifa ();
    vga_sync_gen_if ifb ();

    vga_sync_gen #(.CLK_DIV(4)) u_dut_a (
        .clk   (clk),
        .rst   (rst_a),
        .vga_o (ifa)
    );

    vga_sync_gen #(
        .CLK_DIV(1),
        .H_VISIBLE(BH_V), .H_FRONT(BH_F), .H_SYNC(BH_S), .H_BACK(BH_B),
        .V_VISIBLE(BV_V), .V_FRONT(BV_F), .V_SYNC(BV_S), .V_BACK(BV_B),
        .SYNC_POL(1'b1)
    ) u_dut_b (
        .clk   (clk),
        .rst   (rst_b),
        .vga_o (ifb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Position after c clk edges since reset release is fully determined by the
    // number of completed pixel ticks, c / d.
    function automatic exp_t model(int c, int d, int hv, int hf, int hsw, int hb,
                                   int vv, int vf, int vsw, int vb, bit pol, bit in_rst);
        exp_t e;
        int ht, vt, n, np, ph, pv;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        if (in_rst) begin
            e = '{0, 0, 1'b0, !pol, !pol, 1'b0, 1'b0};
            return e;
        end
        n       = c / d;
        e.h     = n % ht;
        e.v     = (n / ht) % vt;
        e.blank = (e.h >= hv) || (e.v >= vv);
        e.tick  = (c % d) == d - 1;
        e.fs    = (c % d == 0) && (n > 0) && (n % (ht * vt) == 0);
`ifdef VGA_SYNC_ALIGN_EN
        np = (c == 0) ? -1 : (c - 1) / d;
`else
        np = n;
`endif
        if (np < 0) begin
            e.hs = !pol;
            e.vs = !pol;
        end else begin
            ph   = np % ht;
            pv   = (np / ht) % vt;
            e.hs = (ph >= hv + hf && ph < hv + hf + hsw) ? pol : !pol;
            e.vs = (pv >= vv + vf && pv < vv + vf + vsw) ? pol : !pol;
        end
        return e;
    endfunction

    always @(posedge clk) begin
        c_a <= rst_a ? 0 : c_a + 1;
        c_b <= rst_b ? 0 : c_b + 1;
    end

    always @(negedge clk) begin
        exp_t e;
        if (chk_en) begin
            e = model(c_a, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, rst_a);
            check("a_pos_h", ifa.pos_h, e.h);
            check("a_pos_v", ifa.pos_v, e.v);
            check("a_blank", ifa.blank, e.blank);
            check("a_hsync", ifa.hsync, e.hs);
            check("a_vsync", ifa.vsync, e.vs);
            check("a_pix_tick", ifa.pix_tick, e.tick);
            check("a_frame_start", ifa.frame_start, e.fs);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (chk_en) begin
            e = model(c_b, 1, BH_V, BH_F, BH_S, BH_B, BV_V, BV_F, BV_S, BV_B, 1'b1, rst_b);
            check("b_pos_h", ifb.pos_h, e.h);
            check("b_pos_v", ifb.pos_v, e.v);
            check("b_blank", ifb.blank, e.blank);
            check("b_hsync", ifb.hsync, e.hs);
            check("b_vsync", ifb.vsync, e.vs);
            check("b_pix_tick", ifb.pix_tick, e.tick);
            check("b_frame_start", ifb.frame_start, e.fs);
            if (rst_b) begin
                last_fs = -1;
            end else if (ifb.frame_start) begin
                if (last_fs >= 0) check("b_fs_gap", c_b - last_fs, B_FRAME);
                last_fs = c_b;
            end
        end
    end

    initial begin
        @(posedge clk);
        #1 chk_en = 1'b1;
        fork
            begin
                repeat (2) @(posedge clk);
                #1 rst_a = 1'b0;
                repeat ($urandom_range(50, 500)) @(posedge clk);
                // Mid-count reset, asserted between edges to exercise the async path.
                #1 rst_a = 1'b1;
                repeat (3) @(posedge clk);
                #1 rst_a = 1'b0;
                repeat (800 * 4 * 2 + 200) @(posedge clk);
            end
            begin
                repeat (2) @(posedge clk);
                #1 rst_b = 1'b0;
                repeat (3 * B_FRAME + 5) @(posedge clk);
                repeat (12) begin
                    repeat ($urandom_range(1, 700)) @(posedge clk);
                    #1 rst_b = 1'b1;
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1 rst_b = 1'b0;
                end
                repeat (3 * B_FRAME + 5) @(posedge clk);
            end
        join
        @(negedge clk);
        #1 $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
